// File: rtl/cache_pkg.sv
// Shared cache geometry, address field helpers and the refill controller state encoding.
package cache_pkg;

    localparam int ADDR_W   = 32;
    localparam int TAG_W    = 20;
    localparam int INDEX_W  = 8;
    localparam int LINE_W   = 128;
    localparam int BEAT_W   = 32;
    localparam int BEATS    = LINE_W / BEAT_W;
    localparam int CNT_W    = $clog2(BEATS);
    localparam int OFFSET_W = ADDR_W - TAG_W - INDEX_W;
    localparam int WORD_W   = OFFSET_W - 2;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RECV,
        FILL,
        RESP
    } state_e;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W +: INDEX_W];
    endfunction

    // Word within the line; the low two bits select a byte and are not needed here.
    function automatic logic [WORD_W-1:0] addr_word(input logic [ADDR_W-1:0] addr);
        return addr[2 +: WORD_W];
    endfunction

    function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/lru_table.sv
// Per-set 1-bit LRU storage: async victim read, hit and refill write ports, refill wins on a shared set.
module lru_table
    import cache_pkg::*;
(
    input  logic               clk,
    input  logic               rstn,
    input  logic [INDEX_W-1:0] rd_idx_i,
    output logic               rd_way_o,
    input  logic               hit_we_i,
    input  logic [INDEX_W-1:0] hit_idx_i,
    input  logic               hit_data_i,
    input  logic               fill_we_i,
    input  logic [INDEX_W-1:0] fill_idx_i,
    input  logic               fill_data_i
);

    logic [2**INDEX_W-1:0] lru_q;

    assign rd_way_o = lru_q[rd_idx_i];

    // The refill write is issued last so it overrides a hit to the same set.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            lru_q <= '0;
        end else begin
            if (hit_we_i) begin
                lru_q[hit_idx_i] <= hit_data_i;
            end
            if (fill_we_i) begin
                lru_q[fill_idx_i] <= fill_data_i;
            end
        end
    end

endmodule

// File: rtl/refill_ctrl.sv
// Single-outstanding cache miss controller: victim pick, line read, beat assembly, refill pulse, CPU word return.
module refill_ctrl
    import cache_pkg::*;
(
    input  logic               clk,
    input  logic               rstn,
    input  logic               miss_valid,
    input  logic [ADDR_W-1:0]  miss_addr,
    output logic               miss_ready,
    input  logic               hit_valid,
    input  logic [INDEX_W-1:0] hit_index,
    input  logic               hit_way,
    output logic               mem_rreq,
    output logic [ADDR_W-1:0]  mem_raddr,
    input  logic               mem_rrdy,
    input  logic               mem_rvalid,
    input  logic [BEAT_W-1:0]  mem_rdata,
    output logic [LINE_W-1:0]  final_data,
    output logic               refill_ready,
    output logic [INDEX_W-1:0] index,
    output logic [TAG_W-1:0]   tag,
    output logic               way,
    output logic               resp_valid,
    output logic [BEAT_W-1:0]  resp_data
);

    state_e             state_q;
    logic [TAG_W-1:0]   reqTag_q;
    logic [INDEX_W-1:0] reqIndex_q;
    logic [WORD_W-1:0]  reqWord_q;
    logic               victim_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [LINE_W-1:0]  line_q;
    logic [LINE_W-1:0]  line_d;
    logic               missReady_q;
    logic               memRreq_q;
    logic [ADDR_W-1:0]  memRaddr_q;
    logic [LINE_W-1:0]  finalData_q;
    logic               refillReady_q;
    logic [INDEX_W-1:0] index_q;
    logic [TAG_W-1:0]   tag_q;
    logic               way_q;
    logic               respValid_q;
    logic [BEAT_W-1:0]  respData_q;
    logic               lruVictim;

    lru_table u_lru (
        .clk         (clk),
        .rstn        (rstn),
        .rd_idx_i    (addr_index(miss_addr)),
        .rd_way_o    (lruVictim),
        .hit_we_i    (hit_valid),
        .hit_idx_i   (hit_index),
        .hit_data_i  (~hit_way),
        .fill_we_i   (state_q == FILL),
        .fill_idx_i  (index_q),
        .fill_data_i (~way_q)
    );

    // Line buffer with the current beat merged in, so the last beat can be published directly.
    always_comb begin
        line_d = line_q;
        if (state_q == RECV && mem_rvalid) begin
            line_d[int'(cnt_q)*BEAT_W +: BEAT_W] = mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= IDLE;
            reqTag_q      <= '0;
            reqIndex_q    <= '0;
            reqWord_q     <= '0;
            victim_q      <= 1'b0;
            cnt_q         <= '0;
            line_q        <= '0;
            missReady_q   <= 1'b1;
            memRreq_q     <= 1'b0;
            memRaddr_q    <= '0;
            finalData_q   <= '0;
            refillReady_q <= 1'b0;
            index_q       <= '0;
            tag_q         <= '0;
            way_q         <= 1'b0;
            respValid_q   <= 1'b0;
            respData_q    <= '0;
        end else begin
            refillReady_q <= 1'b0;
            respValid_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (miss_valid) begin
                        reqTag_q    <= addr_tag(miss_addr);
                        reqIndex_q  <= addr_index(miss_addr);
                        reqWord_q   <= addr_word(miss_addr);
                        victim_q    <= lruVictim;
                        memRaddr_q  <= line_addr(miss_addr);
                        memRreq_q   <= 1'b1;
                        missReady_q <= 1'b0;
                        state_q     <= REQ;
                    end
                end
                REQ: begin
                    if (mem_rrdy) begin
                        memRreq_q <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= RECV;
                    end
                end
                RECV: begin
                    if (mem_rvalid) begin
                        line_q <= line_d;
                        cnt_q  <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(BEATS-1)) begin
                            finalData_q   <= line_d;
                            index_q       <= reqIndex_q;
                            tag_q         <= reqTag_q;
                            way_q         <= victim_q;
                            refillReady_q <= 1'b1;
                            state_q       <= FILL;
                        end
                    end
                end
                FILL: begin
                    respData_q  <= finalData_q[int'(reqWord_q)*BEAT_W +: BEAT_W];
                    respValid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    missReady_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign miss_ready   = missReady_q;
    assign mem_rreq     = memRreq_q;
    assign mem_raddr    = memRaddr_q;
    assign final_data   = finalData_q;
    assign refill_ready = refillReady_q;
    assign index        = index_q;
    assign tag          = tag_q;
    assign way          = way_q;
    assign resp_valid   = respValid_q;
    assign resp_data    = respData_q;

endmodule

// File: tb/tb_refill_ctrl.sv
// Directed scenario bench for refill_ctrl with hand-computed expectations.
module tb_refill_ctrl;
    import cache_pkg::*;

    logic               clk = 1'b0;
    logic               rstn;
    logic               miss_valid;
    logic [ADDR_W-1:0]  miss_addr;
    logic               miss_ready;
    logic               hit_valid;
    logic [INDEX_W-1:0] hit_index;
    logic               hit_way;
    logic               mem_rreq;
    logic [ADDR_W-1:0]  mem_raddr;
    logic               mem_rrdy;
    logic               mem_rvalid;
    logic [BEAT_W-1:0]  mem_rdata;
    logic [LINE_W-1:0]  final_data;
    logic               refill_ready;
    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   tag;
    logic               way;
    logic               resp_valid;
    logic [BEAT_W-1:0]  resp_data;

    int checks   = 0;
    int failures = 0;

    int                 refillCount = 0;
    int                 respCount   = 0;
    logic [LINE_W-1:0]  capLine;
    logic [INDEX_W-1:0] capIdx;
    logic [TAG_W-1:0]   capTag;
    logic               capWay;
    logic [BEAT_W-1:0]  capResp;

    refill_ctrl dut (
        .clk          (clk),
        .rstn         (rstn),
        .miss_valid   (miss_valid),
        .miss_addr    (miss_addr),
        .miss_ready   (miss_ready),
        .hit_valid    (hit_valid),
        .hit_index    (hit_index),
        .hit_way      (hit_way),
        .mem_rreq     (mem_rreq),
        .mem_raddr    (mem_raddr),
        .mem_rrdy     (mem_rrdy),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .final_data   (final_data),
        .refill_ready (refill_ready),
        .index        (index),
        .tag          (tag),
        .way          (way),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data)
    );

    always #5 clk = ~clk;

    // Pulse monitor: counts refill/response pulses and captures what they carried.
    always @(negedge clk) begin
        if (refill_ready === 1'b1) begin
            refillCount = refillCount + 1;
            capLine     = final_data;
            capIdx      = index;
            capTag      = tag;
            capWay      = way;
        end
        if (resp_valid === 1'b1) begin
            respCount = respCount + 1;
            capResp   = resp_data;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        rstn       = 1'b0;
        miss_valid = 1'b0;
        miss_addr  = '0;
        hit_valid  = 1'b0;
        hit_index  = '0;
        hit_way    = 1'b0;
        mem_rrdy   = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    // Drives one complete miss; optional hit injected during the FILL cycle.
    task automatic runMiss(input logic [ADDR_W-1:0] addr,
                           input logic [BEAT_W-1:0] b0, input logic [BEAT_W-1:0] b1,
                           input logic [BEAT_W-1:0] b2, input logic [BEAT_W-1:0] b3,
                           input int rrdyDelay, input int gap,
                           input logic hitEn, input logic [INDEX_W-1:0] hitIdx, input logic hitWay,
                           output logic rreqOk);
        logic [BEAT_W-1:0] beats [4];
        logic [ADDR_W-1:0] expRaddr;
        beats[0] = b0; beats[1] = b1; beats[2] = b2; beats[3] = b3;
        expRaddr = {addr[ADDR_W-1:4], 4'b0000};
        rreqOk = 1'b1;
        miss_valid = 1'b1;
        miss_addr  = addr;
        tick();
        miss_valid = 1'b0;
        for (int d = 0; d <= rrdyDelay; d++) begin
            if (mem_rreq !== 1'b1 || mem_raddr !== expRaddr) rreqOk = 1'b0;
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hBAD0_0000 + BEAT_W'(d);
            mem_rrdy   = (d == rrdyDelay);
            tick();
        end
        mem_rrdy   = 1'b0;
        mem_rvalid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < gap; g++) tick();
            mem_rvalid = 1'b1;
            mem_rdata  = beats[b];
            tick();
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h5A5A_5A5A;
        end
        if (hitEn) begin
            hit_valid = 1'b1;
            hit_index = hitIdx;
            hit_way   = hitWay;
        end
        tick();
        hit_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_and_basic();
        resetDut();
        checks++;
        if (miss_ready !== 1'b1 || mem_rreq !== 1'b0 || refill_ready !== 1'b0 || resp_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl: got ready=%b rreq=%b refill=%b resp=%b required 1 0 0 0",
                     miss_ready, mem_rreq, refill_ready, resp_valid);
        end
        checks++;
        if (final_data !== '0 || index !== '0 || tag !== '0 || way !== 1'b0 || resp_data !== '0) begin
            failures++;
            $display("[TB] FAIL reset_data: got line=%h idx=%h tag=%h way=%b resp=%h required all zero",
                     final_data, index, tag, way, resp_data);
        end
        miss_valid = 1'b1;
        miss_addr  = 32'h1234_5678;
        tick();
        miss_valid = 1'b0;
        checks++;
        if (mem_rreq !== 1'b1 || mem_raddr !== 32'h1234_5670 || miss_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_req: got rreq=%b raddr=%h ready=%b required 1 12345670 0",
                     mem_rreq, mem_raddr, miss_ready);
        end
        mem_rrdy = 1'b1;
        tick();
        mem_rrdy   = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hA0A0_A0A0;
        tick();
        mem_rdata = 32'hA1A1_A1A1;
        tick();
        mem_rdata = 32'hA2A2_A2A2;
        tick();
        mem_rdata = 32'hA3A3_A3A3;
        tick();
        mem_rvalid = 1'b0;
        checks++;
        if (refill_ready !== 1'b1 || index !== 8'h67 || tag !== 20'h12345 || way !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_fill: got refill=%b idx=%h tag=%h way=%b required 1 67 12345 0",
                     refill_ready, index, tag, way);
        end
        checks++;
        if (final_data !== 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0) begin
            failures++;
            $display("[TB] FAIL basic_line: got %h required A3A3A3A3A2A2A2A2A1A1A1A1A0A0A0A0", final_data);
        end
        tick();
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 32'hA2A2_A2A2 || refill_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_resp: got valid=%b data=%h refill=%b required 1 A2A2A2A2 0",
                     resp_valid, resp_data, refill_ready);
        end
        tick();
        checks++;
        if (miss_ready !== 1'b1 || resp_valid !== 1'b0 ||
            final_data !== 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0) begin
            failures++;
            $display("[TB] FAIL basic_idle: got ready=%b resp=%b line=%h required 1 0 held line",
                     miss_ready, resp_valid, final_data);
        end
    endtask

    task automatic test_stall_and_gaps();
        int   r0, p0;
        logic ok;
        r0 = refillCount;
        p0 = respCount;
        runMiss(32'h1234_5670, 32'hB0B0_0000, 32'hB1B1_1111, 32'hB2B2_2222, 32'hB3B3_3333,
                3, 2, 1'b0, 8'h00, 1'b0, ok);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("[TB] FAIL stall_rreq_stable: got %b required 1", ok);
        end
        checks++;
        if (refillCount - r0 != 1 || respCount - p0 != 1) begin
            failures++;
            $display("[TB] FAIL stall_pulses: got refill=%0d resp=%0d required 1 1", refillCount - r0, respCount - p0);
        end
        checks++;
        if (capLine !== 128'hB3B3_3333_B2B2_2222_B1B1_1111_B0B0_0000 || capResp !== 32'hB0B0_0000) begin
            failures++;
            $display("[TB] FAIL stall_line: got line=%h resp=%h required B3B33333B2B22222B1B11111B0B00000 B0B00000",
                     capLine, capResp);
        end
        checks++;
        if (capWay !== 1'b1 || capTag !== 20'h12345 || capIdx !== 8'h67) begin
            failures++;
            $display("[TB] FAIL stall_way: got way=%b tag=%h idx=%h required 1 12345 67", capWay, capTag, capIdx);
        end
    endtask

    task automatic test_lru_sequence();
        logic ok;
        resetDut();
        runMiss(32'h1234_5678, 32'h1, 32'h2, 32'h3, 32'h4, 0, 0, 1'b0, 8'h00, 1'b0, ok);
        checks++;
        if (capWay !== 1'b0) begin
            failures++;
            $display("[TB] FAIL lru_first: got way=%b required 0", capWay);
        end
        runMiss(32'h1234_5678, 32'h5, 32'h6, 32'h7, 32'h8, 0, 0, 1'b0, 8'h00, 1'b0, ok);
        checks++;
        if (capWay !== 1'b1) begin
            failures++;
            $display("[TB] FAIL lru_second: got way=%b required 1", capWay);
        end
        hit_valid = 1'b1; hit_index = 8'h67; hit_way = 1'b1;
        tick();
        hit_valid = 1'b0;
        runMiss(32'h1234_5678, 32'h9, 32'hA, 32'hB, 32'hC, 0, 0, 1'b0, 8'h00, 1'b0, ok);
        checks++;
        if (capWay !== 1'b0) begin
            failures++;
            $display("[TB] FAIL lru_after_hit1: got way=%b required 0", capWay);
        end
        hit_valid = 1'b1; hit_index = 8'h67; hit_way = 1'b1;
        tick();
        hit_valid = 1'b0;
        runMiss(32'h1234_5678, 32'hD, 32'hE, 32'hF, 32'h10, 0, 0, 1'b0, 8'h00, 1'b0, ok);
        checks++;
        if (capWay !== 1'b0) begin
            failures++;
            $display("[TB] FAIL lru_after_hit2: got way=%b required 0", capWay);
        end
    endtask

    task automatic test_hit_fill_collision();
        logic ok;
        resetDut();
        runMiss(32'hABCD_E100, 32'h11, 32'h12, 32'h13, 32'h14, 0, 0, 1'b0, 8'h00, 1'b0, ok);
        runMiss(32'hABCD_E100, 32'h21, 32'h22, 32'h23, 32'h24, 0, 0, 1'b1, 8'h10, 1'b0, ok);
        checks++;
        if (capWay !== 1'b1 || capIdx !== 8'h10 || capTag !== 20'hABCDE) begin
            failures++;
            $display("[TB] FAIL coll_fill_way: got way=%b idx=%h tag=%h required 1 10 ABCDE", capWay, capIdx, capTag);
        end
        runMiss(32'hABCD_E100, 32'h31, 32'h32, 32'h33, 32'h34, 0, 0, 1'b0, 8'h00, 1'b0, ok);
        checks++;
        if (capWay !== 1'b0) begin
            failures++;
            $display("[TB] FAIL coll_fill_wins: got way=%b required 0", capWay);
        end
        runMiss(32'hABCD_E100, 32'h41, 32'h42, 32'h43, 32'h44, 0, 0, 1'b1, 8'h20, 1'b0, ok);
        runMiss(32'h0000_1200, 32'h51, 32'h52, 32'h53, 32'h54, 0, 0, 1'b0, 8'h00, 1'b0, ok);
        checks++;
        if (capWay !== 1'b1 || capIdx !== 8'h20) begin
            failures++;
            $display("[TB] FAIL coll_other_hit: got way=%b idx=%h required 1 20", capWay, capIdx);
        end
        runMiss(32'hABCD_E100, 32'h61, 32'h62, 32'h63, 32'h64, 0, 0, 1'b0, 8'h00, 1'b0, ok);
        checks++;
        if (capWay !== 1'b0) begin
            failures++;
            $display("[TB] FAIL coll_other_fill: got way=%b required 0", capWay);
        end
    endtask

    task automatic test_reset_mid_recv();
        int   r0, p0;
        logic ok;
        resetDut();
        runMiss(32'h1234_5678, 32'h1, 32'h2, 32'h3, 32'h4, 0, 0, 1'b0, 8'h00, 1'b0, ok);
        r0 = refillCount;
        p0 = respCount;
        miss_valid = 1'b1;
        miss_addr  = 32'h1234_5678;
        tick();
        miss_valid = 1'b0;
        mem_rrdy   = 1'b1;
        tick();
        mem_rrdy   = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hC0C0_C0C0;
        tick();
        mem_rdata = 32'hC1C1_C1C1;
        tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        mem_rdata = 32'hC2C2_C2C2;
        tick();
        mem_rdata = 32'hC3C3_C3C3;
        tick();
        mem_rvalid = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (refillCount - r0 != 0 || respCount - p0 != 0) begin
            failures++;
            $display("[TB] FAIL abort_pulses: got refill=%0d resp=%0d required 0 0", refillCount - r0, respCount - p0);
        end
        checks++;
        if (miss_ready !== 1'b1 || mem_rreq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_idle: got ready=%b rreq=%b required 1 0", miss_ready, mem_rreq);
        end
        checks++;
        if (dut.u_lru.lru_q !== '0) begin
            failures++;
            $display("[TB] FAIL abort_lru_clear: got %h required 0", dut.u_lru.lru_q);
        end
        runMiss(32'h1234_5678, 32'h7, 32'h8, 32'h9, 32'hA, 0, 0, 1'b0, 8'h00, 1'b0, ok);
        checks++;
        if (capWay !== 1'b0 || capLine !== 128'h0000000A_00000009_00000008_00000007) begin
            failures++;
            $display("[TB] FAIL abort_next_miss: got way=%b line=%h required 0 0000000A000000090000000800000007",
                     capWay, capLine);
        end
    endtask

    task automatic test_back_to_back();
        int   r0, p0;
        logic busyOk;
        r0 = refillCount;
        p0 = respCount;
        busyOk = 1'b1;
        miss_valid = 1'b1;
        miss_addr  = 32'h0000_0ABC;
        checks++;
        if (miss_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_ready_c0: got %b required 1", miss_ready);
        end
        tick();
        for (int cyc = 1; cyc <= 7; cyc++) begin
            if (miss_ready !== 1'b0) busyOk = 1'b0;
            mem_rrdy   = (cyc == 1);
            mem_rvalid = (cyc >= 2 && cyc <= 5);
            mem_rdata  = 32'hD000_0000 + BEAT_W'(cyc - 2);
            tick();
        end
        mem_rvalid = 1'b0;
        checks++;
        if (busyOk !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_busy: got ready high during cycles 1..7 required low");
        end
        checks++;
        if (miss_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_ready_c8: got %b required 1", miss_ready);
        end
        miss_valid = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (refillCount - r0 != 1 || respCount - p0 != 1 || mem_rreq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_single: got refill=%0d resp=%0d rreq=%b required 1 1 0",
                     refillCount - r0, respCount - p0, mem_rreq);
        end
        checks++;
        if (capResp !== 32'hD000_0003 || capIdx !== 8'hAB) begin
            failures++;
            $display("[TB] FAIL b2b_resp: got data=%h idx=%h required D0000003 AB", capResp, capIdx);
        end
    endtask

    initial begin
        test_reset_and_basic();
        test_stall_and_gaps();
        test_lru_sequence();
        test_hit_fill_collision();
        test_reset_mid_recv();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
